// File: rtl/ddr3_ui_stream_adapter_if.sv
// Stream-side and DDR3 UI-side signals of the stream adapter.
// "master" is the adapter's view and "slave" is the view of the surrounding logic.
interface ddr3_ui_stream_adapter_if #(
  parameter int MEM_ADDR_DEPTH = 28
);
  logic                      init_calib_complete;
  logic                      i_start;
  logic                      i_dir;
  logic [MEM_ADDR_DEPTH-1:0] i_addr;
  logic [23:0]               i_count;
  logic                      o_busy;
  logic                      o_done;
  logic [31:0]               i_wr_data;
  logic                      i_wr_valid;
  logic                      o_wr_ready;
  logic [31:0]               o_rd_data;
  logic                      o_rd_valid;
  logic [MEM_ADDR_DEPTH-1:0] app_addr;
  logic [2:0]                app_cmd;
  logic                      app_en;
  logic                      app_rdy;
  logic [31:0]               app_wdf_data;
  logic [3:0]                app_wdf_mask;
  logic                      app_wdf_wren;
  logic                      app_wdf_end;
  logic                      app_wdf_rdy;
  logic [31:0]               app_rd_data;
  logic                      app_rd_data_valid;
  logic                      app_rd_data_end;

  modport master (
    input  init_calib_complete, i_start, i_dir, i_addr, i_count,
    input  i_wr_data, i_wr_valid,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    output o_busy, o_done, o_wr_ready, o_rd_data, o_rd_valid,
    output app_addr, app_cmd, app_en,
    output app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );

  modport slave (
    output init_calib_complete, i_start, i_dir, i_addr, i_count,
    output i_wr_data, i_wr_valid,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
    input  o_busy, o_done, o_wr_ready, o_rd_data, o_rd_valid,
    input  app_addr, app_cmd, app_en,
    input  app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end
  );
endinterface

// File: rtl/ddr3_ui_stream_adapter.sv
// Turns a word-stream transfer request into DDR3 UI traffic: two-beat write bursts
// plus write commands, or back-to-back read commands with the returned data streamed out.
module ddr3_ui_stream_adapter #(
  parameter int MEM_ADDR_DEPTH = 28,
  parameter int ADDR_INC       = 8
) (
  input logic                      clk,
  input logic                      rst_n,
  ddr3_ui_stream_adapter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_BEAT0, S_WR_BEAT1, S_WR_CMD, S_RD_CMD, S_RD_DRAIN, S_DONE
  } state_t;

  state_t                    r_state;
  logic [23:0]               r_count;
  logic [23:0]               r_wcnt;
  logic [23:0]               r_ccnt;
  logic [24:0]               r_rcnt;
  logic                      r_busy;
  logic                      r_done;
  logic [31:0]               r_rd_data;
  logic                      r_rd_valid;
  logic [MEM_ADDR_DEPTH-1:0] r_app_addr;
  logic [2:0]                r_app_cmd;
  logic                      r_app_en;
  logic [31:0]               r_wdf_data;
  logic [3:0]                r_wdf_mask;
  logic                      r_wdf_wren;
  logic                      r_wdf_end;

  logic [23:0] w_ncmd;
  logic [24:0] w_total;
  logic        w_last_cmd;
  logic        w_word_left;
  logic        w_beat0_take;
  logic        w_beat1_word;
  logic        w_beat1_pad;
  logic        w_rd_beat;
  logic        w_wr_ready;
  logic        w_unused_rd_end;

  assign w_ncmd       = 24'(({1'b0, r_count} + 25'd1) >> 1);
  assign w_total      = {w_ncmd, 1'b0};
  assign w_last_cmd   = (r_ccnt + 24'd1) == w_ncmd;
  assign w_word_left  = r_wcnt < r_count;
  assign w_beat0_take = (r_state == S_WR_BEAT0) && bus.i_wr_valid && bus.app_wdf_rdy;
  assign w_beat1_word = (r_state == S_WR_BEAT1) && w_word_left && bus.i_wr_valid && bus.app_wdf_rdy;
  assign w_beat1_pad  = (r_state == S_WR_BEAT1) && !w_word_left && bus.app_wdf_rdy;
  assign w_rd_beat    = ((r_state == S_RD_CMD) || (r_state == S_RD_DRAIN)) && bus.app_rd_data_valid;
  assign w_wr_ready   = bus.app_wdf_rdy &&
                        ((r_state == S_WR_BEAT0) || ((r_state == S_WR_BEAT1) && w_word_left));
  assign w_unused_rd_end = bus.app_rd_data_end;

  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
  assign bus.o_wr_ready   = w_wr_ready;
  assign bus.o_rd_data    = r_rd_data;
  assign bus.o_rd_valid   = r_rd_valid;
  assign bus.app_addr     = r_app_addr;
  assign bus.app_cmd      = r_app_cmd;
  assign bus.app_en       = r_app_en;
  assign bus.app_wdf_data = r_wdf_data;
  assign bus.app_wdf_mask = r_wdf_mask;
  assign bus.app_wdf_wren = r_wdf_wren;
  assign bus.app_wdf_end  = r_wdf_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_wcnt     <= '0;
      r_ccnt     <= '0;
      r_rcnt     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_app_addr <= '0;
      r_app_cmd  <= '0;
      r_app_en   <= 1'b0;
      r_wdf_data <= '0;
      r_wdf_mask <= '0;
      r_wdf_wren <= 1'b0;
      r_wdf_end  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_rd_valid <= 1'b0;

      // The write-data register only advances when the UI can take data, so it holds still otherwise.
      if (bus.app_wdf_rdy) begin
        r_wdf_wren <= w_beat0_take | w_beat1_word | w_beat1_pad;
        if (w_beat0_take || w_beat1_word) begin
          r_wdf_data <= bus.i_wr_data;
          r_wdf_mask <= '0;
          r_wdf_end  <= w_beat1_word;
          r_wcnt     <= r_wcnt + 24'd1;
        end else if (w_beat1_pad) begin
          r_wdf_data <= '0;
          r_wdf_mask <= '1;
          r_wdf_end  <= 1'b1;
        end
      end

      case (r_state)
        S_IDLE: begin
          if (bus.i_start && bus.init_calib_complete) begin
            r_count    <= bus.i_count;
            r_wcnt     <= '0;
            r_ccnt     <= '0;
            r_rcnt     <= '0;
            r_busy     <= 1'b1;
            r_app_addr <= bus.i_addr;
            r_app_cmd  <= {2'b00, bus.i_dir};
            if (bus.i_count == 24'd0) begin
              r_state <= S_DONE;
            end else if (bus.i_dir) begin
              r_app_en <= 1'b1;
              r_state  <= S_RD_CMD;
            end else begin
              r_state <= S_WR_BEAT0;
            end
          end
        end
        S_WR_BEAT0: if (w_beat0_take) r_state <= S_WR_BEAT1;
        S_WR_BEAT1: if (w_beat1_word || w_beat1_pad) r_state <= S_WR_CMD;
        S_WR_CMD: begin
          // Raise the command only once the burst's second beat has left the data register.
          if (!r_app_en) begin
            if (!r_wdf_wren || bus.app_wdf_rdy) r_app_en <= 1'b1;
          end else if (bus.app_rdy) begin
            r_app_en   <= 1'b0;
            r_app_addr <= r_app_addr + MEM_ADDR_DEPTH'(ADDR_INC);
            r_ccnt     <= r_ccnt + 24'd1;
            if (w_last_cmd) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_state <= S_WR_BEAT0;
            end
          end
        end
        S_RD_CMD: begin
          if (bus.app_rdy) begin
            r_app_addr <= r_app_addr + MEM_ADDR_DEPTH'(ADDR_INC);
            r_ccnt     <= r_ccnt + 24'd1;
            if (w_last_cmd) begin
              r_app_en <= 1'b0;
              r_state  <= S_RD_DRAIN;
            end
          end
        end
        S_RD_DRAIN: ;
        S_DONE: begin
          // A zero-length start arrives here without a pulse; finished transfers arrive with one.
          if (r_done) begin
            r_state <= S_IDLE;
          end else begin
            r_done <= 1'b1;
            r_busy <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (w_rd_beat) begin
        r_rcnt     <= r_rcnt + 25'd1;
        r_rd_data  <= bus.app_rd_data;
        r_rd_valid <= r_rcnt < {1'b0, r_count};
        if ((r_rcnt + 25'd1) == w_total) begin
          r_state  <= S_DONE;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_app_en <= 1'b0;
        end
      end
    end
  end

endmodule
